// File: rtl/window_score_pkg.sv
// Shared defaults and FSM state type for the window_score slice.
package window_score_pkg;

  localparam int DW_DEF     = 10;
  localparam int N_DEF      = 8;
  localparam int AW_DEF     = 24;
  localparam int STRIDE_DEF = 1;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_dot_tree.sv
// Two-stage N-way signed dot product: registered products, registered sum.
// WINDOW_SCORE_RELU_EN clamps negative sums to zero before the sum register.
module window_dot_tree
  import window_score_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prod_en,
  input  logic                 sum_en,
  input  logic [N*DW-1:0]      win_in,
  input  logic [N*DW-1:0]      w_flat,
  output logic signed [AW-1:0] sum
);

  logic signed [2*DW-1:0] prod_q [N];
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum_d;

  // NOTE: product registers carry data only and are qualified by a separate
  // valid, so they are left unreset; this keeps them as plain flops.
  always_ff @(posedge clk) begin
    if (prod_en) begin
      for (int i = 0; i < N; i++) begin
        prod_q[i] <= (2*DW)'(signed'(win_in[i*DW +: DW])) *
                     (2*DW)'(signed'(w_flat[i*DW +: DW]));
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + {{(AW-2*DW){prod_q[i][2*DW-1]}}, prod_q[i]};
    end
`ifdef WINDOW_SCORE_RELU_EN
    sum_d = acc[AW-1] ? '0 : acc;
`else
    sum_d = acc;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum <= '0;
    else if (sum_en) sum <= sum_d;
  end

endmodule

// File: rtl/window_score.sv
// Strided dot-product scorer over a sliding window with a held output register.
// Optional WINDOW_SCORE_RELU_EN clamps negative scores to zero.
module window_score
  import window_score_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N      = N_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*DW-1:0]       win_in,
  input  logic                  win_valid,
  input  logic                  flush,
  input  logic                  w_wr,
  input  logic [$clog2(N)-1:0]  w_addr,
  input  logic [DW-1:0]         w_data,
  output logic signed [AW-1:0]  score,
  output logic                  score_valid,
  input  logic                  score_ready,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int CW = cnt_w(N);

  state_e          state;
  logic [CW-1:0]   fill_cnt;
  logic [CW-1:0]   stride_cnt;
  logic [DW-1:0]   w_q [N];
  logic [N*DW-1:0] w_flat;
  logic            launch;
  logic            prod_v;
  logic            load;
  logic            drop;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    launch = 1'b0;
    if (win_valid && !flush) begin
      launch = (state == FILL) ? (fill_cnt   == CW'(N-1))
                               : (stride_cnt == CW'(STRIDE-1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      fill_cnt   <= '0;
      stride_cnt <= '0;
    end else if (flush) begin
      state      <= FILL;
      fill_cnt   <= '0;
      stride_cnt <= '0;
    end else if (win_valid) begin
      case (state)
        FILL: begin
          if (fill_cnt == CW'(N-1)) begin
            state      <= RUN;
            fill_cnt   <= '0;
            stride_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        RUN: stride_cnt <= (stride_cnt == CW'(STRIDE-1)) ? '0 : stride_cnt + 1'b1;
        default: state <= FILL;
      endcase
    end
  end

  // Weights are written behind the launch: the products sample the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) w_q[i] <= '0;
    end else if (w_wr) begin
      w_q[w_addr] <= w_data;
    end
  end

  always_comb begin
    w_flat = '0;
    for (int i = 0; i < N; i++) w_flat[i*DW +: DW] = w_q[i];
  end

  // A stage-2 result either lands in the output register or is dropped.
  assign load = prod_v && !flush && (!score_valid || score_ready);
  assign drop = prod_v && !flush && score_valid && !score_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_v      <= 1'b0;
      score_valid <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      prod_v <= launch;
      if (flush)            score_valid <= 1'b0;
      else if (load)        score_valid <= 1'b1;
      else if (score_ready) score_valid <= 1'b0;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  window_dot_tree #(
    .DW (DW),
    .N  (N),
    .AW (AW)
  ) u_dot (
    .clk     (clk),
    .rst     (rst),
    .prod_en (launch),
    .sum_en  (load),
    .win_in  (win_in),
    .w_flat  (w_flat),
    .sum     (score)
  );

endmodule
